tracking_ctrl: RTL and testbench
================================

TRACKING_CTRL -- requirements
Module: tracking_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, frame height in pixels.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 8192, result wait window after the last pixel.
REQ-004 SHALL have parameter MIN_SIZE, default 4, minimum accepted width/height.
REQ-005 SHALL have parameter LOCK_FRAMES, default 3, consecutive accepted frames needed to assert lock.
REQ-006 SHALL have parameter LOST_FRAMES, default 8, consecutive rejected frames needed to assert lost.
REQ-007 SHALL have parameter RST_CYCLES, default 4, tracker resync pulse length.
REQ-008 SHALL have ports: clock_50 in 1 sole clock; reset in 1 synchronous active-low reset.
REQ-009 SHALL have ports: enable in 1 run request; frame_start in 1 vsync pulse; pix_valid in 1 camera pixel strobe.
REQ-010 SHALL have ports: trk_full in 1 tracker FIFO full; trk_valid in 1 tracker result strobe; trk_center_x, trk_center_y, trk_width, trk_height in 12 each, tracker result.
REQ-011 SHALL have ports: trk_wr_en out 1 gated pixel write; trk_rst_n out 1 tracker reset, active-low.
REQ-012 SHALL have ports: obj_x, obj_y, obj_w, obj_h out 12 each, last accepted box; obj_upd out 1 one-cycle update strobe; lock out 1; lost out 1; busy out 1; drop_cnt out 8 resync counter.

Function
REQ-013 SHALL implement states IDLE, ARM, STREAM, WAIT_RES, RESYNC.
REQ-014 IDLE SHALL go to ARM when enable=1; ARM SHALL return to IDLE when enable=0, else go to STREAM on frame_start.
REQ-015 In STREAM, trk_wr_en SHALL equal pix_valid combinationally; in all other states it SHALL be 0.
REQ-016 STREAM SHALL count written pixels with a 19-bit counter; on the write numbered WIDTH*HEIGHT it SHALL go to WAIT_RES and clear the counter.
REQ-017 If pix_valid=1 and trk_full=1 in the same STREAM cycle, the block SHALL go to RESYNC, increment drop_cnt, and saturate it at 255.
REQ-018 If frame_start arrives in STREAM before WIDTH*HEIGHT writes, the block SHALL treat it as a short frame and apply REQ-017.
REQ-019 RESYNC SHALL hold trk_rst_n=0 for exactly RST_CYCLES cycles, clear the pixel counter, then go to ARM; outside RESYNC, trk_rst_n SHALL be 1.
REQ-020 WAIT_RES SHALL count cycles; the frame SHALL be accepted when trk_valid=1, trk_width>=MIN_SIZE, and trk_height>=MIN_SIZE.
REQ-021 The frame SHALL be rejected when trk_valid=1 with an undersized box, or when the count reaches TIMEOUT_CYCLES with no trk_valid.
REQ-022 On accept or reject, WAIT_RES SHALL go to ARM, or to IDLE if enable=0. frame_start during WAIT_RES SHALL be ignored, so that frame is skipped.
REQ-023 On accept, the block SHALL register the tracker result into obj_* and pulse obj_upd for one cycle, on the cycle after trk_valid.
REQ-024 On accept, the block SHALL increment the accept streak (saturating at LOCK_FRAMES) and clear the reject streak; lock SHALL assert when the accept streak reaches LOCK_FRAMES; lost SHALL clear.
REQ-025 On reject, the block SHALL increment the reject streak (saturating at LOST_FRAMES) and clear the accept streak and lock; lost SHALL assert when the reject streak reaches LOST_FRAMES; obj_* SHALL hold.
REQ-026 trk_valid outside WAIT_RES SHALL be ignored.
REQ-027 busy SHALL be 1 in STREAM, WAIT_RES and RESYNC, and 0 otherwise.
REQ-028 enable=0 in STREAM SHALL NOT abort the frame; it takes effect at the end of WAIT_RES.

Reset
REQ-029 On reset=0 sampled at a clock_50 edge, the block SHALL enter IDLE and clear all counters, both streaks, obj_*, obj_upd, lock, lost, busy, drop_cnt and trk_wr_en, and SHALL drive trk_rst_n=0.
REQ-030 Reset SHALL take effect mid-frame in any state, with no partial result emitted.

Structure
REQ-031 The state enum SHALL live in shared package tracking_pkg, with the 12-bit coordinate width constant.
REQ-032 The streak/lock/lost logic SHALL be a sub-module track_qualifier, with inputs accept and reject and outputs lock and lost.

Verification
REQ-033 Bench SHALL drive enable=1 and frame_start, then 307200 pix_valid with trk_full=0, then trk_valid with a 20x10 box at (100,50); it SHALL check exactly 307200 trk_wr_en, then obj_upd=1 and obj_x=100.
REQ-034 Bench SHALL drive three consecutive accepted frames and check lock=1 after the third obj_upd.
REQ-035 Bench SHALL drive eight frames with no trk_valid and check each WAIT_RES ends at 8192 cycles, then lost=1, lock=0, with obj_* unchanged.
REQ-036 Bench SHALL drive trk_full=1 with pix_valid=1 at pixel 1000 and check trk_rst_n=0 for exactly 4 cycles, drop_cnt=1, and state ARM.
REQ-037 Bench SHALL drive frame_start at pixel 5000 and check a resync; it SHALL drive 256 overflows and check drop_cnt=255.
REQ-038 Bench SHALL assert reset mid-STREAM and check all outputs at reset values the next cycle, and that a trk_valid arriving then produces no obj_upd.

Source files
------------

// File: rtl/tracking_pkg.sv
// Shared types for the tracking controller: FSM states and coordinate width.
package tracking_pkg;

   localparam int COORD_W = 12;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      STREAM,
      WAIT_RES,
      RESYNC
   } trk_state_t;

endpackage

// File: rtl/tracking_ctrl_if.sv
// Pixel/result link between the tracking controller and the object tracker core.
interface tracking_ctrl_if;
   import tracking_pkg::*;

   logic   trk_wr_en;
   logic   trk_rst_n;
   logic   trk_full;
   logic   trk_valid;
   coord_t trk_center_x;
   coord_t trk_center_y;
   coord_t trk_width;
   coord_t trk_height;

   modport master (
      output trk_wr_en, trk_rst_n,
      input  trk_full, trk_valid, trk_center_x, trk_center_y, trk_width, trk_height
   );

   modport slave (
      input  trk_wr_en, trk_rst_n,
      output trk_full, trk_valid, trk_center_x, trk_center_y, trk_width, trk_height
   );

endinterface

// File: rtl/track_qualifier.sv
// Accept/reject streak tracking that turns per-frame verdicts into lock and lost flags.
module track_qualifier #(
   parameter int LOCK_FRAMES = 3,
   parameter int LOST_FRAMES = 8
) (
   input  logic clock_50,
   input  logic reset,
   input  logic accept,
   input  logic reject,
   output logic lock,
   output logic lost
);

   localparam int AW = $clog2(LOCK_FRAMES + 1);
   localparam int RW = $clog2(LOST_FRAMES + 1);

   logic [AW-1:0] acc_q, acc_d;
   logic [RW-1:0] rej_q, rej_d;

   function automatic logic [AW-1:0] sat_acc(input logic [AW-1:0] v);
      return (v >= AW'(LOCK_FRAMES)) ? AW'(LOCK_FRAMES) : v + AW'(1);
   endfunction

   function automatic logic [RW-1:0] sat_rej(input logic [RW-1:0] v);
      return (v >= RW'(LOST_FRAMES)) ? RW'(LOST_FRAMES) : v + RW'(1);
   endfunction

   always_comb begin
      acc_d = sat_acc(acc_q);
      rej_d = sat_rej(rej_q);
   end

   always_ff @(posedge clock_50) begin
      if (!reset) begin
         acc_q <= '0;
         rej_q <= '0;
         lock  <= 1'b0;
         lost  <= 1'b0;
      end else if (accept) begin
         acc_q <= acc_d;
         rej_q <= '0;
         lock  <= (acc_d == AW'(LOCK_FRAMES));
         lost  <= 1'b0;
      end else if (reject) begin
         rej_q <= rej_d;
         acc_q <= '0;
         lock  <= 1'b0;
         lost  <= (rej_d == RW'(LOST_FRAMES));
      end
   end

endmodule

// File: rtl/tracking_ctrl.sv
// Frame-level controller: gates camera pixels into the tracker, waits for its box,
// qualifies the result and resynchronises the tracker on overflow or short frames.
module tracking_ctrl
   import tracking_pkg::*;
#(
   parameter int WIDTH          = 640,
   parameter int HEIGHT         = 480,
   parameter int TIMEOUT_CYCLES = 8192,
   parameter int MIN_SIZE       = 4,
   parameter int LOCK_FRAMES    = 3,
   parameter int LOST_FRAMES    = 8,
   parameter int RST_CYCLES     = 4
) (
   input  logic            clock_50,
   input  logic            reset,
   input  logic            enable,
   input  logic            frame_start,
   input  logic            pix_valid,
   tracking_ctrl_if.master trk,
   output coord_t          obj_x,
   output coord_t          obj_y,
   output coord_t          obj_w,
   output coord_t          obj_h,
   output logic            obj_upd,
   output logic            lock,
   output logic            lost,
   output logic            busy,
   output logic [7:0]      drop_cnt
);

   localparam logic [18:0] FRAME_LAST = 19'(WIDTH * HEIGHT - 1);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W = $clog2(RST_CYCLES + 1);

   trk_state_t      state_q, state_d;
   logic [18:0]     pix_cnt_q;
   logic [TO_W-1:0] wait_cnt_q;
   logic [RC_W-1:0] rst_cnt_q;
   logic            rst_done_q;

   logic overflow, short_frame, frame_done;
   logic res_good, res_accept, res_reject;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Overflow outranks an early vsync, which outranks normal frame completion.
   always_comb begin
      overflow    = (state_q == STREAM) && pix_valid && trk.trk_full;
      short_frame = (state_q == STREAM) && frame_start && !overflow;
      frame_done  = (state_q == STREAM) && pix_valid && !overflow && !frame_start
                    && (pix_cnt_q == FRAME_LAST);
      res_good    = (trk.trk_width >= coord_t'(MIN_SIZE)) && (trk.trk_height >= coord_t'(MIN_SIZE));
      res_accept  = (state_q == WAIT_RES) && trk.trk_valid && res_good;
      res_reject  = (state_q == WAIT_RES)
                    && ((trk.trk_valid && !res_good)
                        || (!trk.trk_valid && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (enable) state_d = ARM;
         ARM: begin
            if (!enable)          state_d = IDLE;
            else if (frame_start) state_d = STREAM;
         end
         STREAM: begin
            if (overflow || short_frame) state_d = RESYNC;
            else if (frame_done)         state_d = WAIT_RES;
         end
         WAIT_RES: if (res_accept || res_reject) state_d = enable ? ARM : IDLE;
         RESYNC:   if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = ARM;
         default:  state_d = IDLE;
      endcase
   end

   // Tracker reset stays low for the cycle after a controller reset as well as in RESYNC.
   always_comb begin
      trk.trk_wr_en = 1'b0;
      trk.trk_rst_n = rst_done_q;
      busy          = 1'b0;
      case (state_q)
         STREAM: begin
            trk.trk_wr_en = pix_valid;
            busy          = 1'b1;
         end
         WAIT_RES: busy = 1'b1;
         RESYNC: begin
            trk.trk_rst_n = 1'b0;
            busy          = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_50) begin
      if (!reset) begin
         state_q    <= IDLE;
         pix_cnt_q  <= '0;
         wait_cnt_q <= '0;
         rst_cnt_q  <= '0;
         rst_done_q <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         rst_done_q <= 1'b1;
         pix_cnt_q  <= (state_q == STREAM && state_d == STREAM) ? pix_cnt_q + 19'(pix_valid) : '0;
         wait_cnt_q <= (state_q == WAIT_RES && state_d == WAIT_RES) ? wait_cnt_q + TO_W'(1) : '0;
         rst_cnt_q  <= (state_q == RESYNC && state_d == RESYNC) ? rst_cnt_q + RC_W'(1) : '0;
         if (overflow || short_frame) drop_cnt <= sat_inc8(drop_cnt);
      end
   end

   always_ff @(posedge clock_50) begin
      if (!reset) begin
         obj_x   <= '0;
         obj_y   <= '0;
         obj_w   <= '0;
         obj_h   <= '0;
         obj_upd <= 1'b0;
      end else begin
         obj_upd <= res_accept;
         if (res_accept) begin
            obj_x <= trk.trk_center_x;
            obj_y <= trk.trk_center_y;
            obj_w <= trk.trk_width;
            obj_h <= trk.trk_height;
         end
      end
   end

   track_qualifier #(
      .LOCK_FRAMES(LOCK_FRAMES),
      .LOST_FRAMES(LOST_FRAMES)
   ) u_qualifier (
      .clock_50(clock_50),
      .reset   (reset),
      .accept  (res_accept),
      .reject  (res_reject),
      .lock    (lock),
      .lost    (lost)
   );

endmodule

// File: tb/tb_tracking_ctrl.sv
// Directed bench for tracking_ctrl with a reduced frame size and result timeout.
module tb_tracking_ctrl;
   import tracking_pkg::*;

   localparam int W     = 80;
   localparam int H     = 64;
   localparam int FRAME = W * H;
   localparam int TO    = 512;

   logic       clock_50 = 1'b0;
   logic       reset;
   logic       enable;
   logic       frame_start;
   logic       pix_valid;
   coord_t     obj_x, obj_y, obj_w, obj_h;
   logic       obj_upd, lock, lost, busy;
   logic [7:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int rst_low = 0;
   int upd_cnt = 0;

   tracking_ctrl_if ifc ();

   tracking_ctrl #(
      .WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(TO), .MIN_SIZE(4),
      .LOCK_FRAMES(3), .LOST_FRAMES(8), .RST_CYCLES(4)
   ) dut (
      .clock_50   (clock_50),
      .reset      (reset),
      .enable     (enable),
      .frame_start(frame_start),
      .pix_valid  (pix_valid),
      .trk        (ifc),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .obj_w      (obj_w),
      .obj_h      (obj_h),
      .obj_upd    (obj_upd),
      .lock       (lock),
      .lost       (lost),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   always #10 clock_50 = ~clock_50;

   always @(negedge clock_50) begin
      if (ifc.trk_wr_en)  wr_cnt  <= wr_cnt + 1;
      if (!ifc.trk_rst_n) rst_low <= rst_low + 1;
      if (obj_upd)        upd_cnt <= upd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_50);
      #1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic stream(input int n);
      pix_valid = 1'b1;
      repeat (n) step();
      pix_valid = 1'b0;
   endtask

   task automatic result(input int x, input int y, input int w, input int h);
      ifc.trk_center_x = coord_t'(x);
      ifc.trk_center_y = coord_t'(y);
      ifc.trk_width    = coord_t'(w);
      ifc.trk_height   = coord_t'(h);
      ifc.trk_valid    = 1'b1;
      step();
      ifc.trk_valid    = 1'b0;
   endtask

   task automatic wait_while(input trk_state_t s, input int limit, output int n);
      n = 0;
      while (dut.state_q == s && n < limit) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int base;
      reset = 1'b0; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
      ifc.trk_full = 1'b0; ifc.trk_valid = 1'b0;
      ifc.trk_center_x = '0; ifc.trk_center_y = '0; ifc.trk_width = '0; ifc.trk_height = '0;
      step(); step();
      check("rst_trk_rst_n", 32'(ifc.trk_rst_n), 32'd0);
      check("rst_busy",      32'(busy),          32'd0);
      check("rst_wr_en",     32'(ifc.trk_wr_en), 32'd0);
      check("rst_drop",      32'(drop_cnt),      32'd0);
      check("rst_lock_lost", 32'({lock, lost, obj_upd}), 32'd0);

      // Frame 1: full frame then a 20x10 box at (100,50).
      reset = 1'b1; enable = 1'b1;
      step();
      check("arm_state",   32'(dut.state_q),   32'(ARM));
      check("arm_rst_n",   32'(ifc.trk_rst_n), 32'd1);
      start_frame();
      base = wr_cnt;
      stream(FRAME);
      check("f1_wr_cnt", 32'(wr_cnt - base), 32'(FRAME));
      check("f1_state",  32'(dut.state_q),   32'(WAIT_RES));
      check("f1_busy",   32'(busy),          32'd1);
      repeat (3) step();
      result(100, 50, 20, 10);
      check("f1_upd",   32'(obj_upd), 32'd1);
      check("f1_obj_x", 32'(obj_x),   32'd100);
      check("f1_obj_y", 32'(obj_y),   32'd50);
      check("f1_obj_wh", 32'({obj_w, obj_h}), {8'd0, 12'd20, 12'd10});
      check("f1_lock",  32'(lock),    32'd0);
      step();
      check("f1_upd_pulse", 32'(obj_upd), 32'd0);

      // Frames 2 and 3 accepted; height exactly MIN_SIZE on the third.
      start_frame(); stream(FRAME); result(200, 150, 30, 40);
      check("f2_lock", 32'(lock), 32'd0);
      start_frame(); stream(FRAME); result(300, 250, 8, 4);
      check("f3_upd",  32'(obj_upd), 32'd1);
      check("f3_lock", 32'(lock),    32'd1);

      // FIFO overflow at pixel 1000.
      start_frame(); stream(999);
      pix_valid = 1'b1; ifc.trk_full = 1'b1;
      step();
      pix_valid = 1'b0; ifc.trk_full = 1'b0;
      check("ovf_state", 32'(dut.state_q), 32'(RESYNC));
      base = rst_low;
      wait_while(RESYNC, 20, n);
      check("ovf_len",      32'(n),              32'd4);
      check("ovf_rst_low",  32'(rst_low - base), 32'd4);
      check("ovf_drop",     32'(drop_cnt),       32'd1);
      check("ovf_arm",      32'(dut.state_q),    32'(ARM));
      check("ovf_rst_n",    32'(ifc.trk_rst_n),  32'd1);

      // Early vsync at pixel 5000.
      start_frame(); stream(4999);
      frame_start = 1'b1; pix_valid = 1'b1;
      step();
      frame_start = 1'b0; pix_valid = 1'b0;
      check("short_state", 32'(dut.state_q), 32'(RESYNC));
      wait_while(RESYNC, 20, n);
      check("short_drop", 32'(drop_cnt),    32'd2);
      check("short_arm",  32'(dut.state_q), 32'(ARM));
      check("short_lock", 32'(lock),        32'd1);

      // 256 overflows: counter saturates at 255.
      for (int i = 0; i < 256; i++) begin
         start_frame();
         pix_valid = 1'b1; ifc.trk_full = 1'b1;
         step();
         pix_valid = 1'b0; ifc.trk_full = 1'b0;
         wait_while(RESYNC, 20, n);
         if (i == 251) check("drop_254", 32'(drop_cnt), 32'd254);
      end
      check("drop_sat", 32'(drop_cnt), 32'd255);

      // Eight timed-out frames.
      base = upd_cnt;
      for (int i = 0; i < 8; i++) begin
         start_frame(); stream(FRAME);
         wait_while(WAIT_RES, 2 * TO, n);
         check("to_len",  32'(n),    32'(TO));
         check("to_lost", 32'(lost), 32'(i == 7));
         check("to_lock", 32'(lock), 32'd0);
      end
      check("to_no_upd", 32'(upd_cnt - base), 32'd0);
      check("to_obj_x",  32'(obj_x), 32'd300);
      check("to_obj_y",  32'(obj_y), 32'd250);
      check("to_obj_wh", 32'({obj_w, obj_h}), {8'd0, 12'd8, 12'd4});

      // Undersized box is a reject.
      start_frame(); stream(FRAME); result(400, 350, 3, 20);
      check("small_upd",   32'(obj_upd),       32'd0);
      check("small_obj_x", 32'(obj_x),         32'd300);
      check("small_lost",  32'(lost),          32'd1);
      check("small_state", 32'(dut.state_q),   32'(ARM));

      // enable drops mid-stream: frame still completes, then IDLE.
      start_frame();
      pix_valid = 1'b1;
      repeat (10) step();
      enable = 1'b0;
      repeat (FRAME - 10) step();
      pix_valid = 1'b0;
      check("en_state_wait", 32'(dut.state_q), 32'(WAIT_RES));
      result(11, 22, 33, 44);
      check("en_upd",   32'(obj_upd),     32'd1);
      check("en_obj",   32'({obj_x, obj_h}), {8'd0, 12'd11, 12'd44});
      check("en_lost",  32'(lost),        32'd0);
      check("en_idle",  32'(dut.state_q), 32'(IDLE));

      // Reset mid-stream.
      enable = 1'b1;
      step();
      start_frame();
      pix_valid = 1'b1;
      repeat (100) step();
      reset = 1'b0;
      step();
      check("mid_wr_en",  32'(ifc.trk_wr_en), 32'd0);
      check("mid_rst_n",  32'(ifc.trk_rst_n), 32'd0);
      check("mid_busy",   32'(busy),          32'd0);
      check("mid_drop",   32'(drop_cnt),      32'd0);
      check("mid_obj",    32'({obj_x, obj_w}), 32'd0);
      check("mid_flags",  32'({obj_upd, lock, lost}), 32'd0);
      check("mid_state",  32'(dut.state_q),   32'(IDLE));
      reset = 1'b0; pix_valid = 1'b0;
      reset = 1'b1;
      base = upd_cnt;
      ifc.trk_center_x = 12'd50; ifc.trk_center_y = 12'd60;
      ifc.trk_width = 12'd70; ifc.trk_height = 12'd80;
      ifc.trk_valid = 1'b1;
      step(); step();
      ifc.trk_valid = 1'b0;
      step();
      check("post_no_upd", 32'(upd_cnt - base), 32'd0);
      check("post_obj_x",  32'(obj_x),          32'd0);
      check("post_rst_n",  32'(ifc.trk_rst_n),  32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
